// File: rtl/mem_line_ctrl.sv
// Cache line/word request to single-word req/ack bus sequencer.
// Optional bus watchdog enabled with `define MEMCTL_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | ready, waiting for a cache request
// W_BEAT    | issuing write beats, one per bus_ack
// R_BEAT    | issuing read beats, capturing bus_rdata on bus_ack
// DONE      | one-cycle mem_done pulse
// RELEASE   | wait for all request levels to drop before re-arming
module mem_line_ctrl #(
   parameter int ADDR_W         = 26,
   parameter int LINE_WORDS     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst_l,
   input  logic                        mem_w_line,
   input  logic                        mem_r_line,
   input  logic                        mem_w_one,
   input  logic                        mem_r_one,
   input  logic [ADDR_W-1:0]           mem_addr,
   input  logic [LINE_WORDS-1:0][31:0] line_store,
   output logic [LINE_WORDS-1:0][31:0] line_read,
   output logic                        mem_ready,
   output logic                        mem_done,
   output logic                        mem_err,
   output logic                        bus_req,
   output logic                        bus_we,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic [31:0]                 bus_wdata,
   input  logic                        bus_ack,
   input  logic [31:0]                 bus_rdata
);

   localparam int BW = $clog2(LINE_WORDS);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_W_BEAT  = 3'd1;
   localparam logic [2:0] S_R_BEAT  = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   logic [2:0]                  r_state;
   logic [BW-1:0]               r_k;
   logic [BW-1:0]               r_last_k;
   logic [LINE_WORDS-1:0][31:0] r_data;
   logic [LINE_WORDS-1:0][31:0] r_line_read;
   logic                        r_bus_req;
   logic                        r_bus_we;
   logic [ADDR_W-1:0]           r_bus_addr;
   logic [31:0]                 r_bus_wdata;

   logic                        w_any_req;
   logic                        w_is_line;
   logic                        w_is_write;
   logic [ADDR_W-1:0]           w_base;
   logic                        w_ack;
   logic                        w_last;
   logic [BW-1:0]               w_k_nxt;
   logic                        w_tmo;

   assign w_any_req  = mem_w_line | mem_r_line | mem_w_one | mem_r_one;
   assign w_is_line  = mem_w_line | mem_r_line;
   // w_line > r_line > w_one > r_one
   assign w_is_write = mem_w_line | (~mem_r_line & mem_w_one);
   assign w_base     = w_is_line ? (mem_addr & ~ADDR_W'(LINE_WORDS-1)) : mem_addr;
   assign w_ack      = bus_ack & r_bus_req;
   assign w_last     = (r_k == r_last_k);
   assign w_k_nxt    = r_k + BW'(1);

`ifdef MEMCTL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_tmr;
   logic          r_err;

   // Down-counter reloaded at every beat start; terminal count with no ack aborts.
   assign w_tmo = r_bus_req & ~bus_ack & (r_tmr == '0);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_tmr <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_any_req) begin
            r_tmr <= TW'(TIMEOUT_CYCLES - 1);
            r_err <= 1'b0;
         end else if (w_ack) begin
            r_tmr <= TW'(TIMEOUT_CYCLES - 1);
         end else if (w_tmo) begin
            r_err <= 1'b1;
         end else if (r_bus_req && r_tmr != '0) begin
            r_tmr <= r_tmr - TW'(1);
         end
      end
   end

   assign mem_err = r_err;
`else
   logic w_unused_cfg;

   assign w_tmo        = 1'b0;
   assign w_unused_cfg = (TIMEOUT_CYCLES > 0) | w_tmo;
   assign mem_err      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_last_k    <= '0;
         r_data      <= '0;
         r_line_read <= '0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state     <= w_is_write ? S_W_BEAT : S_R_BEAT;
                  r_data      <= line_store;
                  r_k         <= '0;
                  r_last_k    <= w_is_line ? BW'(LINE_WORDS - 1) : '0;
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= w_is_write;
                  r_bus_addr  <= w_base;
                  r_bus_wdata <= line_store[0];
               end
            end
            S_W_BEAT, S_R_BEAT: begin
               if (w_ack) begin
                  if (r_state == S_R_BEAT) begin
                     r_line_read[r_k] <= bus_rdata;
                  end
                  r_k <= w_k_nxt;
                  if (w_last) begin
                     r_bus_req <= 1'b0;
                     r_state   <= S_DONE;
                  end else begin
                     r_bus_addr  <= r_bus_addr + ADDR_W'(1);
                     r_bus_wdata <= r_data[w_k_nxt];
                  end
               end else if (w_tmo) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!w_any_req) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign line_read = r_line_read;
   assign mem_ready = (r_state == S_IDLE);
   assign mem_done  = (r_state == S_DONE);
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl: stimulus queues expected bus beats and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_line_ctrl;
   localparam int AW = 26;
   localparam int LW = 8;

   logic                clk = 1'b0;
   logic                rst_l = 1'b0;
   logic                mem_w_line = 1'b0, mem_r_line = 1'b0;
   logic                mem_w_one = 1'b0, mem_r_one = 1'b0;
   logic [AW-1:0]       mem_addr = '0;
   logic [LW-1:0][31:0] line_store = '0;
   logic [LW-1:0][31:0] line_read;
   logic                mem_ready, mem_done, mem_err;
   logic                bus_req, bus_we;
   logic [AW-1:0]       bus_addr;
   logic [31:0]         bus_wdata;
   logic                bus_ack = 1'b0;
   logic [31:0]         bus_rdata = '0;

   always #5 clk = ~clk;

   mem_line_ctrl #(.ADDR_W(AW), .LINE_WORDS(LW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_l(rst_l),
      .mem_w_line(mem_w_line), .mem_r_line(mem_r_line),
      .mem_w_one(mem_w_one), .mem_r_one(mem_r_one),
      .mem_addr(mem_addr), .line_store(line_store), .line_read(line_read),
      .mem_ready(mem_ready), .mem_done(mem_done), .mem_err(mem_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] wdata; } bus_t;
   typedef struct { logic [LW-1:0][31:0] lr; logic err; } done_t;

   bus_t                exp_bus[$];
   done_t               exp_done[$];
   int                  n_tests = 0;
   int                  n_fail = 0;
   int                  wait_cycles = 0;
   logic                never_ack = 1'b0;
   int                  ack_count = 0;
   logic [LW-1:0][31:0] m_lr = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_bus(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
      bus_t e;
      e.we = we; e.addr = a; e.wdata = d;
      exp_bus.push_back(e);
   endtask

   task automatic push_done(input logic err);
      done_t d;
      d.lr = m_lr; d.err = err;
      exp_done.push_back(d);
   endtask

   task automatic issue(input logic wl, input logic rl, input logic wo, input logic ro,
                        input logic [AW-1:0] a);
      int g = 0;
      @(posedge clk); #2;
      while (!mem_ready && g < 100) begin
         @(posedge clk); #2;
         g++;
      end
      if (g >= 100) chk("ready_wait_timeout", 0, 1);
      mem_w_line = wl; mem_r_line = rl; mem_w_one = wo; mem_r_one = ro; mem_addr = a;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!mem_done && cyc < 500);
      if (!mem_done) chk("done_wait_timeout", 0, 1);
   endtask

   task automatic drop_req();
      mem_w_line = 0; mem_r_line = 0; mem_w_one = 0; mem_r_one = 0;
   endtask

   // Memory model: ack follows wait_cycles+1 cycles of bus_req; read data = 0xA0000000 + addr.
   initial begin
      int cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst_l || bus_ack) begin
            bus_ack = 1'b0;
            cnt = 0;
         end
         if (rst_l && bus_req && !never_ack) begin
            if (cnt >= wait_cycles + 1) begin
               bus_ack   = 1'b1;
               bus_rdata = 32'hA000_0000 + 32'(bus_addr);
               ack_count++;
            end else begin
               cnt++;
            end
         end
      end
   end

   // Monitor
   initial begin
      logic          prev_req = 0, prev_ack = 0, prev_done = 0;
      logic [AW-1:0] prev_addr = '0;
      logic [31:0]   prev_wdata = '0;
      bus_t          e;
      done_t         d;
      forever begin
         @(negedge clk);
         if (rst_l && bus_req && bus_ack) begin
            if (exp_bus.size() == 0) begin
               chk("bus_unexpected_beat", {bus_we, 6'd0, bus_addr}, 0);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_we", bus_we, e.we);
               chk("bus_addr", bus_addr, e.addr);
               if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
            end
         end
         if (rst_l && bus_req && prev_req && !prev_ack) begin
            chk("bus_addr_stable", bus_addr, prev_addr);
            chk("bus_wdata_stable", bus_wdata, prev_wdata);
         end
         if (rst_l && mem_done) begin
            chk("done_single_pulse", prev_done, 0);
            if (exp_done.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               d = exp_done.pop_front();
               chk("line_read", line_read, d.lr);
               chk("mem_err", mem_err, d.err);
            end
         end
         prev_req = bus_req; prev_ack = bus_ack; prev_addr = bus_addr;
         prev_wdata = bus_wdata; prev_done = mem_done;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int cyc;
      int g;
      int a0;

      // Reset values
      #12;
      chk("rst_mem_ready", mem_ready, 1);
      chk("rst_mem_done", mem_done, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_line_read", line_read, 0);
      @(negedge clk); rst_l = 1'b1;

      // Line read, zero-wait: base 0x10, mem_done in the 18th cycle counting the request cycle
      wait_cycles = 0;
      for (int k = 0; k < LW; k++) begin
         push_bus(1'b0, 26'h10 + 26'(k), 32'h0);
         m_lr[k] = 32'hA000_0010 + 32'(k);
      end
      push_done(1'b0);
      issue(0, 1, 0, 0, 26'h00013);
      wait_done(cyc);
      chk("r_line_latency", cyc, 17);
      drop_req();

      // Line write, 3-cycle wait per beat; line_read untouched
      wait_cycles = 3;
      for (int k = 0; k < LW; k++) begin
         line_store[k] = 32'h11 * 32'(k);
         push_bus(1'b1, 26'h23450 + 26'(k), 32'h11 * 32'(k));
      end
      push_done(1'b0);
      issue(1, 0, 0, 0, 26'h23456);
      wait_done(cyc);
      drop_req();

      // One-word write held 3 cycles past mem_done
      wait_cycles = 0;
      line_store = '{default: 32'h5555_5555};
      line_store[0] = 32'hDEAD_BEEF;
      push_bus(1'b1, 26'h20005, 32'hDEAD_BEEF);
      push_done(1'b0);
      issue(0, 0, 1, 0, 26'h20005);
      wait_done(cyc);
      chk("w_one_latency", cyc, 3);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("held_req_not_ready", mem_ready, 0);
         chk("held_req_no_bus", bus_req, 0);
      end
      drop_req();
      @(posedge clk); #1;
      chk("ready_after_release", mem_ready, 1);

      // w_line and r_one together: only the line write runs
      for (int k = 0; k < LW; k++) begin
         line_store[k] = 32'h1000 + 32'(k);
         push_bus(1'b1, 26'h100 + 26'(k), 32'h1000 + 32'(k));
      end
      push_done(1'b0);
      issue(1, 0, 0, 1, 26'h00107);
      wait_done(cyc);
      drop_req();

      // Reset during beat 4 of a line read
      for (int k = 0; k < LW; k++) push_bus(1'b0, 26'h40 + 26'(k), 32'h0);
      a0 = ack_count;
      issue(0, 1, 0, 0, 26'h00040);
      g = 0;
      while (ack_count < a0 + 4 && g < 500) begin
         @(posedge clk); #2;
         g++;
      end
      if (g >= 500) chk("beat4_wait_timeout", 0, 1);
      @(posedge clk); #3;
      rst_l = 1'b0;
      drop_req();
      exp_bus.delete();
      exp_done.delete();
      m_lr = '0;
      #1;
      chk("midrst_bus_req", bus_req, 0);
      chk("midrst_line_read", line_read, 0);
      @(negedge clk); @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready", mem_ready, 1);

      // One-word read at top of address space after reset
      push_bus(1'b0, 26'h3FF_FFFF, 32'h0);
      m_lr[0] = 32'hA3FF_FFFF;
      push_done(1'b0);
      issue(0, 0, 0, 1, 26'h3FF_FFFF);
      wait_done(cyc);
      chk("r_one_latency", cyc, 3);
      drop_req();

`ifdef MEMCTL_TIMEOUT_EN
      // Bus never acks: watchdog aborts beat 0 after 16 cycles of bus_req
      never_ack = 1'b1;
      push_done(1'b1);
      issue(0, 1, 0, 0, 26'h00080);
      wait_done(cyc);
      chk("tmo_latency", cyc, 17);
      drop_req();
      never_ack = 1'b0;
      push_bus(1'b0, 26'h00081, 32'h0);
      m_lr[0] = 32'hA000_0081;
      push_done(1'b0);
      issue(0, 0, 0, 1, 26'h00081);
      @(posedge clk); #1;
      chk("tmo_err_cleared", mem_err, 0);
      wait_done(cyc);
      drop_req();
`endif

      repeat (4) @(posedge clk);
      #1;
      chk("bus_queue_empty", exp_bus.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
